// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the shared shift-and-add multiplier: FSM encoding,
// default operand width and step-counter sizing.
package mul_share_ctrl_pkg;

   localparam int unsigned DEFAULT_SIZE = 8;
   localparam int unsigned CNT_W        = $clog2(DEFAULT_SIZE);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   // Keeps the step counter at least one bit wide for degenerate sizes.
   function automatic int unsigned cnt_width(input int unsigned size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/mul_add_row.sv
// SIZE-bit ripple-carry adder row built from one-bit full-adder cells,
// carry-in tied low; the only arithmetic in the multiplier.
module mul_add_row
   import mul_share_ctrl_pkg::*;
#(
   parameter int unsigned SIZE = DEFAULT_SIZE
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] sum,
   output logic            cout
);

   logic [SIZE:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < SIZE; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[SIZE];

endmodule

// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end sharing one sequential shift-and-add
// multiplier; one step per cycle over SIZE cycles, done pulse to the owner.
module mul_share_ctrl
   import mul_share_ctrl_pkg::*;
#(
   parameter int unsigned SIZE = DEFAULT_SIZE
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iReq0,
   input  logic [SIZE-1:0]   iA0,
   input  logic [SIZE-1:0]   iB0,
   input  logic              iReq1,
   input  logic [SIZE-1:0]   iA1,
   input  logic [SIZE-1:0]   iB1,
   output logic              oGnt0,
   output logic              oGnt1,
   output logic              oBusy,
   output logic              oDone0,
   output logic              oDone1,
   output logic [2*SIZE-1:0] oProduct
);

   localparam int unsigned CW = cnt_width(SIZE);
   localparam logic [CW-1:0] LAST_STEP = CW'(SIZE - 1);

   state_t            state;
   logic [SIZE-1:0]   mcand;
   logic [2*SIZE-1:0] acc;
   logic [CW-1:0]     cnt;
   logic              rr;
   logic              owner;

   logic              pick1;
   logic [SIZE-1:0]   addend;
   logic [SIZE-1:0]   sum;
   logic              cout;

   // Requester 1 wins when it is the only one asking, or on a tie when rr points at it.
   assign pick1  = iReq1 & (~iReq0 | rr);
   assign addend = acc[0] ? mcand : '0;

   mul_add_row #(
      .SIZE (SIZE)
   ) u_add_row (
      .a    (acc[2*SIZE-1:SIZE]),
      .b    (addend),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= StIdle;
         mcand    <= '0;
         acc      <= '0;
         cnt      <= '0;
         rr       <= 1'b0;
         owner    <= 1'b0;
         oGnt0    <= 1'b0;
         oGnt1    <= 1'b0;
         oBusy    <= 1'b0;
         oDone0   <= 1'b0;
         oDone1   <= 1'b0;
         oProduct <= '0;
      end else begin
         oGnt0  <= 1'b0;
         oGnt1  <= 1'b0;
         oDone0 <= 1'b0;
         oDone1 <= 1'b0;
         unique case (state)
            StIdle: begin
               if (iReq0 | iReq1) begin
                  owner <= pick1;
                  mcand <= pick1 ? iA1 : iA0;
                  acc   <= {{SIZE{1'b0}}, (pick1 ? iB1 : iB0)};
                  cnt   <= '0;
                  oGnt0 <= ~pick1;
                  oGnt1 <= pick1;
                  oBusy <= 1'b1;
                  state <= StRun;
               end
            end
            StRun: begin
               acc <= {cout, sum, acc[SIZE-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state <= StDone;
               end
            end
            StDone: begin
               oProduct <= acc;
               oDone0   <= ~owner;
               oDone1   <= owner;
               rr       <= ~owner;
               oBusy    <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
